// File: rtl/mdr_mem_unit.sv
// mdr_mem_unit
//   Memory-side stage of the datapath. Holds the memory address register (MAR)
//   and memory data register (MDR). Sequences single-word reads and writes
//   against a word memory that answers with a variable-latency ready handshake.
//   An access that sees no ready within TIMEOUT request cycles is aborted.
//
// Ports
//   clk          in   clock, rising edge
//   clr          in   synchronous active-high reset
//   BusMuxOut    in   shared bus value (address/data source)
//   MARin        in   load MAR from BusMuxOut[ADDR_W-1:0] (IDLE only)
//   MDRin        in   load MDR from BusMuxOut (IDLE only)
//   Read         in   start a read at MAR (IDLE only, wins over Write)
//   Write        in   start a write of MDR to MAR (IDLE only)
//   BusMuxInMDR  out  MDR contents, a bus mux source
//   mem_addr     out  MAR
//   mem_wdata    out  MDR
//   mem_rd       out  read request, high exactly while in RD
//   mem_wr       out  write request, high exactly while in WR
//   mem_rdata    in   read data, valid with mem_ready
//   mem_ready    in   memory completes the current request
//   busy         out  access in progress
//   done         out  one-cycle pulse, access completed
//   err          out  one-cycle pulse, access aborted by timeout

module mdr_mem_unit #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 9,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [DATA_W-1:0] BusMuxOut,
    input  logic              MARin,
    input  logic              MDRin,
    input  logic              Read,
    input  logic              Write,
    output logic [DATA_W-1:0] BusMuxInMDR,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } state_t;

    localparam logic [7:0] TMO = 8'(TIMEOUT);

    state_t            state;
    logic [7:0]        count;
    logic [ADDR_W-1:0] mar;
    logic [DATA_W-1:0] mdr;

    assign BusMuxInMDR = mdr;
    assign mem_addr    = mar;
    assign mem_wdata   = mdr;

    always_ff @(posedge clk) begin
        if (clr) begin
            state  <= IDLE;
            count  <= 8'd0;
            mar    <= '0;
            mdr    <= '0;
            mem_rd <= 1'b0;
            mem_wr <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            // done/err are single-cycle pulses unless re-armed below
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    // Register loads land on the same edge as the strobe, so
                    // an access started together with a load uses the new value.
                    if (MARin) mar <= BusMuxOut[ADDR_W-1:0];
                    if (MDRin) mdr <= BusMuxOut;
                    if (Read) begin
                        state  <= RD;
                        count  <= 8'd1;
                        mem_rd <= 1'b1;
                        busy   <= 1'b1;
                    end else if (Write) begin
                        state  <= WR;
                        count  <= 8'd1;
                        mem_wr <= 1'b1;
                        busy   <= 1'b1;
                    end
                end
                RD, WR: begin
                    // count is the number of request cycles so far, including
                    // the current one; ready on the last allowed cycle wins.
                    if (mem_ready) begin
                        if (state == RD) mdr <= mem_rdata;
                        state  <= IDLE;
                        count  <= 8'd0;
                        mem_rd <= 1'b0;
                        mem_wr <= 1'b0;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                    end else if (count == TMO) begin
                        state  <= IDLE;
                        count  <= 8'd0;
                        mem_rd <= 1'b0;
                        mem_wr <= 1'b0;
                        busy   <= 1'b0;
                        err    <= 1'b1;
                    end else begin
                        count <= count + 8'd1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    count  <= 8'd0;
                    mem_rd <= 1'b0;
                    mem_wr <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdr_mem_unit.sv
// tb_mdr_mem_unit
//   Directed bench for mdr_mem_unit. The stimulus process issues accesses and
//   pushes the expected completion (done or err, final MDR, request-cycle
//   counts) into a queue; a monitor pops and compares on every done/err pulse.
//   A small memory model answers requests after a programmable number of
//   request cycles (0 = never answer).

module tb_mdr_mem_unit;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 9;
    localparam int TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              clr;
    logic [DATA_W-1:0] BusMuxOut;
    logic              MARin, MDRin, Read, Write;
    logic [DATA_W-1:0] BusMuxInMDR;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_rd, mem_wr;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    logic              busy, done, err;

    mdr_mem_unit #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .BusMuxOut  (BusMuxOut),
        .MARin      (MARin),
        .MDRin      (MDRin),
        .Read       (Read),
        .Write      (Write),
        .BusMuxInMDR(BusMuxInMDR),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_err;
        logic [31:0] mdr;
        int          rd_cyc;
        int          wr_cyc;
    } exp_t;

    exp_t exp_q[$];

    int nvec  = 0;
    int nfail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        nvec++;
        if (act !== req) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    // ---------------- memory model ----------------
    int          ready_after = 0;
    logic [31:0] rdata_val   = '0;
    int          rq          = 0;

    initial begin
        mem_ready = 1'b0;
        mem_rdata = 32'hBADBAD00;
    end

    always @(negedge clk) begin
        if (mem_rd || mem_wr) begin
            rq++;
            if (ready_after != 0 && rq == ready_after) begin
                mem_ready = 1'b1;
                mem_rdata = rdata_val;
            end else begin
                mem_ready = 1'b0;
                mem_rdata = 32'hBADBAD00;
            end
        end else begin
            rq        = 0;
            mem_ready = 1'b0;
            mem_rdata = 32'hBADBAD00;
        end
    end

    // ---------------- monitor ----------------
    int rd_cyc = 0;
    int wr_cyc = 0;

    always @(negedge clk) begin
        if (clr) begin
            rd_cyc = 0;
            wr_cyc = 0;
        end else begin
            if (mem_rd) rd_cyc++;
            if (mem_wr) wr_cyc++;
            if (done || err) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done_err", {30'd0, done, err}, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("mon_done", {31'd0, done}, {31'd0, !e.is_err});
                    chk("mon_err", {31'd0, err}, {31'd0, e.is_err});
                    chk("mon_mdr", BusMuxInMDR, e.mdr);
                    chk("mon_rd_cycles", rd_cyc, e.rd_cyc);
                    chk("mon_wr_cycles", wr_cyc, e.wr_cyc);
                end
                rd_cyc = 0;
                wr_cyc = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        chk({nm, "_idle_bound"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic push(input bit is_err, input logic [31:0] mdr, input int rc, input int wc);
        exp_t e;
        e.is_err = is_err;
        e.mdr    = mdr;
        e.rd_cyc = rc;
        e.wr_cyc = wc;
        exp_q.push_back(e);
    endtask

    initial begin
        clr = 1'b1; BusMuxOut = '0;
        MARin = 1'b0; MDRin = 1'b0; Read = 1'b0; Write = 1'b0;
        repeat (3) tick();

        // reset state
        chk("rst_mem_addr", {23'd0, mem_addr}, 32'd0);
        chk("rst_mdr", BusMuxInMDR, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
        chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        clr = 1'b0;
        tick();

        // 1) MAR and MDR loads, no access
        MARin = 1'b1; BusMuxOut = 32'h0000_0123;
        tick();
        MARin = 1'b0;
        chk("t1_mar", {23'd0, mem_addr}, 32'h123);
        MDRin = 1'b1; BusMuxOut = 32'hDEAD_BEEF;
        tick();
        MDRin = 1'b0;
        chk("t1_mdr", BusMuxInMDR, 32'hDEADBEEF);
        chk("t1_busy", {31'd0, busy}, 32'd0);

        // 2) read, ready after 3 request cycles; MAR loaded in the same cycle
        ready_after = 3; rdata_val = 32'h1234_5678;
        push(1'b0, 32'h1234_5678, 3, 0);
        MARin = 1'b1; BusMuxOut = 32'h0000_00AB; Read = 1'b1;
        tick();
        MARin = 1'b0; Read = 1'b0;
        chk("t2_busy", {31'd0, busy}, 32'd1);
        chk("t2_mem_rd", {31'd0, mem_rd}, 32'd1);
        chk("t2_addr", {23'd0, mem_addr}, 32'h0AB);
        wait_idle("t2");
        tick();
        chk("t2_mdr", BusMuxInMDR, 32'h12345678);

        // 3) write, zero-wait; MDR loaded together with the Write strobe
        MARin = 1'b1; BusMuxOut = 32'h0000_0005;
        tick();
        MARin = 1'b0;
        ready_after = 1;
        push(1'b0, 32'hCAFE_F00D, 0, 1);
        MDRin = 1'b1; BusMuxOut = 32'hCAFE_F00D; Write = 1'b1;
        tick();
        MDRin = 1'b0; Write = 1'b0;
        chk("t3_mem_wr", {31'd0, mem_wr}, 32'd1);
        chk("t3_wdata", mem_wdata, 32'hCAFEF00D);
        chk("t3_addr", {23'd0, mem_addr}, 32'h005);
        wait_idle("t3");
        tick();

        // 4a) read with no ready: timeout after 15 request cycles, MDR kept
        ready_after = 0;
        push(1'b1, 32'hCAFE_F00D, 15, 0);
        Read = 1'b1;
        tick();
        Read = 1'b0;
        wait_idle("t4a");
        tick();
        chk("t4a_mdr", BusMuxInMDR, 32'hCAFEF00D);

        // 4b) ready on exactly the 15th request cycle wins over timeout
        ready_after = 15; rdata_val = 32'h0F0F_1515;
        push(1'b0, 32'h0F0F_1515, 15, 0);
        Read = 1'b1;
        tick();
        Read = 1'b0;
        wait_idle("t4b");
        tick();

        // 5) Read+Write together: read only; MDRin while busy ignored
        ready_after = 2; rdata_val = 32'h55AA_55AA;
        push(1'b0, 32'h55AA_55AA, 2, 0);
        Read = 1'b1; Write = 1'b1;
        tick();
        Read = 1'b0; Write = 1'b0;
        MDRin = 1'b1; MARin = 1'b1; BusMuxOut = 32'h0000_0001;
        chk("t5_mem_wr", {31'd0, mem_wr}, 32'd0);
        tick();
        MDRin = 1'b0; MARin = 1'b0;
        chk("t5_wdata_stable", mem_wdata, 32'h0F0F1515);
        chk("t5_addr_stable", {23'd0, mem_addr}, 32'h005);
        wait_idle("t5");
        tick();
        chk("t5_mdr", BusMuxInMDR, 32'h55AA55AA);

        // 6) clr on the 2nd RD cycle, then a normal read
        ready_after = 0;
        Read = 1'b1;
        tick();
        Read = 1'b0;
        tick();
        clr = 1'b1;
        tick();
        chk("t6_mem_rd", {31'd0, mem_rd}, 32'd0);
        chk("t6_mar", {23'd0, mem_addr}, 32'd0);
        chk("t6_mdr", BusMuxInMDR, 32'd0);
        chk("t6_busy", {31'd0, busy}, 32'd0);
        chk("t6_done_err", {30'd0, done, err}, 32'd0);
        clr = 1'b0;
        tick();
        ready_after = 1; rdata_val = 32'h600D_F00D;
        push(1'b0, 32'h600D_F00D, 1, 0);
        MARin = 1'b1; BusMuxOut = 32'h0000_01FF; Read = 1'b1;
        tick();
        MARin = 1'b0; Read = 1'b0;
        chk("t6_addr", {23'd0, mem_addr}, 32'h1FF);
        wait_idle("t6");
        repeat (3) tick();
        chk("t6_mdr_after", BusMuxInMDR, 32'h600DF00D);

        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
